tcb_lib_arbiter_rr: RTL and testbench
=====================================

# tcb_lib_arbiter_rr

Round-robin arbiter that shares one TCB subordinate port between MPN TCB managers. It sits between several requesters (e.g. instruction fetch, load/store, debug) and a single shared subordinate such as a memory or a register slice. Each request is granted atomically. A DLY-deep ownership pipeline routes every fixed-delay response back to the manager that issued it.

## Interface
Parameters:
- MPN, 2: number of managers; 2..8.
- ADR, 32: address width.
- DAT, 32: data width.
- BEW, DAT/8: byte enable width.
- DLY, 1: response delay in cycles, shared by all ports; 0..4.
- IDW, $clog2(MPN): grant index width.

Ports (sub_* vectors are indexed by manager number; packed arrays [MPN-1:0][W-1:0]):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sub_vld  in  MPN  request valid, per manager.
- sub_wen  in  MPN  write enable.
- sub_adr  in  MPN×ADR  address.
- sub_ben  in  MPN×BEW  byte enables.
- sub_wdt  in  MPN×DAT  write data.
- sub_rdy  out  MPN  ready; one-hot or zero.
- sub_rdt  out  MPN×DAT  read data response.
- sub_err  out  MPN  error response.
- man_vld  out  1  request valid to the shared subordinate.
- man_wen/man_adr/man_ben/man_wdt  out  1/ADR/BEW/DAT  muxed request.
- man_rdy  in  1  subordinate ready.
- man_rdt  in  DAT  subordinate read data.
- man_err  in  1  subordinate error.

## Operation
- Transfer on a port: vld & rdy at a rising edge. A manager holds its request stable until its transfer.
- Registered state:
  - ptr (IDW): priority pointer.
  - lck (1) and lid (IDW): grant lock.
  - own_vld[DLY] and own_id[DLY][IDW]: ownership pipeline, present only when DLY>0.
- Grant selection (combinational):
  - If lck=1, gid=lid.
  - Otherwise gid is the first index i with sub_vld[i]=1, scanning ptr, ptr+1, …, MPN-1, 0, …, ptr-1 (modulo MPN).
  - gnt=1 when any sub_vld is set, or when lck=1.
- Request path:
  - man_vld = gnt & sub_vld[gid].
  - man_wen/adr/ben/wdt = the fields of manager gid.
  - sub_rdy[gid] = man_rdy & gnt; every other sub_rdy is 0.
- Lock FSM, states OPEN (lck=0) and HELD (lck=1):
  - OPEN→HELD when man_vld & ~man_rdy; lid←gid.
  - HELD→OPEN when man_vld & man_rdy.
  - A stalled request is never re-arbitrated, so the subordinate sees a stable request.
- Pointer: on every man transfer, ptr←(gid+1) mod MPN. This includes the wrap from MPN-1 to 0. Otherwise ptr is unchanged.
- Ownership pipeline (DLY>0):
  - Stage 0 loads own_vld←(man_vld & man_rdy) and own_id←gid.
  - Each stage shifts by one per cycle.
  - The stage at index DLY-1 marks the cycle in which the response is valid.
- Response routing:
  - sub_rdt[i] = man_rdt for all i (broadcast).
  - sub_err[i] = man_err & rv & (rid==i).
    - DLY>0: rv=own_vld[DLY-1], rid=own_id[DLY-1].
    - DLY=0: rv=man_vld&man_rdy, rid=gid.

## Timing
- Reset values: ptr=0, lck=0, lid=0, own_vld=0, own_id=0.
- During reset: man_vld=0 only if all sub_vld=0 (the path is combinational); sub_err=0.
- Request-path latency is 0 cycles (combinational mux).
- Response latency equals DLY, unchanged from the subordinate. Back-to-back transfers from different managers overlap in the pipeline without bubbles.
- Throughput is one transfer per cycle, with the grant rotating when several managers request.
- Simultaneous requests: the lowest index at or after ptr wins. The loser's sub_rdy stays 0 and it retries the next cycle.
- Single requester: it is granted every cycle regardless of ptr.
- rst asserted mid-operation:
  - Pending pipeline entries are discarded and their sub_err responses suppressed immediately.
  - The lock is dropped.
  - Subsequent arbitration restarts from ptr=0.
- Misbehaving requester: if the locked manager drops sub_vld while HELD, man_vld=0 and the lock remains HELD. This is a protocol violation. The bench flags it with an assertion; the RTL does not recover from it.
- MPN=1 degenerates to a pass-through plus the pipeline (IDW forced to 1, ptr constant 0).

## Test plan
- Single manager (MPN=2, DLY=1): mgr 0 writes adr 0x10 data 0x01234567, then reads adr 0x10. Required: man_adr=0x10 in the transfer cycle; sub_rdt[0]=0x01234567 exactly 1 cycle after the read transfer; ptr=1 after each transfer.
- Contention: both managers assert vld in the same cycle with ptr=0, man_rdy=1, and hold it for 4 cycles. Required: grants go 0,1,0,1; each sub_rdy is one-hot; man_adr alternates between the two managers' addresses.
- Stall and lock: mgr 1 requests, then man_rdy=0 for 3 cycles while mgr 0 also requests. Required: gid stays 1 and lck=1 throughout; man_adr is stable; mgr 1 completes when man_rdy=1, and mgr 0 is granted the next cycle.
- Response routing (DLY=2, MPN=3): transfers from mgr 2, 0, 1 on consecutive cycles, with man_err=1 on the second response only. Required: sub_err[0]=1 in cycle t+3 and is 0 at every other index and cycle.
- Wrap-around (MPN=3): ptr=2, requests from mgr 0 and 2. Required: mgr 2 is granted and ptr becomes 0; mgr 0 is granted next.
- Reset mid-flight (DLY=2): assert rst one cycle after a read transfer. Required: own_vld=0 immediately, no sub_err pulse, and ptr=0 and lck=0 after rst deasserts.

Source files
------------

// File: rtl/tcb_lib_arbiter_rr.sv
// Round-robin arbiter that shares one TCB subordinate port between MPN managers.
// Requests are granted atomically: a stalled request stays locked to its
// manager until it completes. A DLY-deep ownership pipeline routes each
// fixed-delay error response back to the manager that issued the request.
//
// Lock FSM
//   state | meaning
//   OPEN  | no stalled request, grant is chosen by the round-robin scan
//   HELD  | the request from manager lid was stalled, grant is pinned to lid

module tcb_lib_arbiter_rr #(
   parameter int unsigned MPN = 2,
   parameter int unsigned ADR = 32,
   parameter int unsigned DAT = 32,
   parameter int unsigned BEW = DAT/8,
   parameter int unsigned DLY = 1,
   parameter int unsigned IDW = (MPN > 1) ? $clog2(MPN) : 1
)(
   input  logic                     clk,
   input  logic                     rst,
   // manager-facing ports, indexed by manager number
   input  logic [MPN-1:0]           sub_vld,
   input  logic [MPN-1:0]           sub_wen,
   input  logic [MPN-1:0][ADR-1:0]  sub_adr,
   input  logic [MPN-1:0][BEW-1:0]  sub_ben,
   input  logic [MPN-1:0][DAT-1:0]  sub_wdt,
   output logic [MPN-1:0]           sub_rdy,
   output logic [MPN-1:0][DAT-1:0]  sub_rdt,
   output logic [MPN-1:0]           sub_err,
   // shared subordinate port
   output logic                     man_vld,
   output logic                     man_wen,
   output logic [ADR-1:0]           man_adr,
   output logic [BEW-1:0]           man_ben,
   output logic [DAT-1:0]           man_wdt,
   input  logic                     man_rdy,
   input  logic [DAT-1:0]           man_rdt,
   input  logic                     man_err
);

   typedef enum logic {
      OPEN = 1'b0,
      HELD = 1'b1
   } lck_state_t;

   lck_state_t       state;
   logic             lck;
   logic [IDW-1:0]   lid;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   scan_id;
   logic             scan_hit;
   logic [IDW-1:0]   gid;
   logic             gnt;
   logic             xfer;
   logic [IDW-1:0]   ptr_nxt;
   logic             rv;
   logic [IDW-1:0]   rid;

   assign lck = (state == HELD);

   // round-robin scan: first requesting index at or after ptr, wrapping modulo MPN
   always_comb begin
      logic [IDW-1:0] idx;
      scan_id  = '0;
      scan_hit = 1'b0;
      idx      = '0;
      // descending distance so the closest requester is the last (winning) write
      for (int k = int'(MPN) - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr) + k) % int'(MPN));
         if (sub_vld[idx]) begin
            scan_id  = idx;
            scan_hit = 1'b1;
         end
      end
   end

   assign gid  = lck ? lid : scan_id;
   assign gnt  = lck | scan_hit;

   // request path: combinational mux of the granted manager
   assign man_vld = gnt & sub_vld[gid];
   assign man_wen = sub_wen[gid];
   assign man_adr = sub_adr[gid];
   assign man_ben = sub_ben[gid];
   assign man_wdt = sub_wdt[gid];
   assign xfer    = man_vld & man_rdy;

   // ready goes only to the granted manager
   always_comb begin
      sub_rdy      = '0;
      sub_rdy[gid] = man_rdy & gnt;
   end

   // lock FSM: pin the grant while the subordinate stalls a request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OPEN;
         lid   <= '0;
      end else begin
         case (state)
            OPEN: begin
               if (man_vld && !man_rdy) begin
                  state <= HELD;
                  lid   <= gid;
               end
            end
            HELD: begin
               if (xfer) begin
                  state <= OPEN;
               end
            end
            default: state <= OPEN;
         endcase
      end
   end

   assign ptr_nxt = IDW'((int'(gid) + 1) % int'(MPN));

   // priority pointer moves just past the winner of each completed transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= ptr_nxt;
      end
   end

   generate
      if (DLY > 0) begin : g_own
         logic [DLY-1:0]           own_vld;
         logic [DLY-1:0][IDW-1:0]  own_id;

         // ownership pipeline: records who issued each transfer until its response
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               own_vld <= '0;
               own_id  <= '0;
            end else begin
               own_vld[0] <= xfer;
               own_id[0]  <= gid;
               for (int s = 1; s < int'(DLY); s++) begin
                  own_vld[s] <= own_vld[s-1];
                  own_id[s]  <= own_id[s-1];
               end
            end
         end

         assign rv  = own_vld[DLY-1];
         assign rid = own_id[DLY-1];
      end else begin : g_own_none
         // zero-delay response belongs to the current transfer; nothing survives reset
         assign rv  = xfer & ~rst;
         assign rid = gid;
      end
   endgenerate

   // response routing: data is broadcast, error is steered to the owner
   always_comb begin
      for (int i = 0; i < int'(MPN); i++) begin
         sub_rdt[i] = man_rdt;
         sub_err[i] = man_err & rv & (rid == IDW'(i));
      end
   end

endmodule

// File: tb/tb_tcb_lib_arbiter_rr.sv
// Bench for tcb_lib_arbiter_rr (MPN=3, DLY=2). A driver issues randomized
// requests and subordinate responses, predicts each cycle's outcome from the
// round-robin rules and queues it; a monitor pops and compares at negedge.

module tb_tcb_lib_arbiter_rr;

   localparam int MPN = 3;
   localparam int ADR = 32;
   localparam int DAT = 32;
   localparam int BEW = DAT/8;
   localparam int DLY = 2;

   logic                     clk;
   logic                     rst;
   logic [MPN-1:0]           sub_vld;
   logic [MPN-1:0]           sub_wen;
   logic [MPN-1:0][ADR-1:0]  sub_adr;
   logic [MPN-1:0][BEW-1:0]  sub_ben;
   logic [MPN-1:0][DAT-1:0]  sub_wdt;
   logic [MPN-1:0]           sub_rdy;
   logic [MPN-1:0][DAT-1:0]  sub_rdt;
   logic [MPN-1:0]           sub_err;
   logic                     man_vld;
   logic                     man_wen;
   logic [ADR-1:0]           man_adr;
   logic [BEW-1:0]           man_ben;
   logic [DAT-1:0]           man_wdt;
   logic                     man_rdy;
   logic [DAT-1:0]           man_rdt;
   logic                     man_err;

   tcb_lib_arbiter_rr #(
      .MPN (MPN),
      .ADR (ADR),
      .DAT (DAT),
      .BEW (BEW),
      .DLY (DLY)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sub_vld (sub_vld),
      .sub_wen (sub_wen),
      .sub_adr (sub_adr),
      .sub_ben (sub_ben),
      .sub_wdt (sub_wdt),
      .sub_rdy (sub_rdy),
      .sub_rdt (sub_rdt),
      .sub_err (sub_err),
      .man_vld (man_vld),
      .man_wen (man_wen),
      .man_adr (man_adr),
      .man_ben (man_ben),
      .man_wdt (man_wdt),
      .man_rdy (man_rdy),
      .man_rdt (man_rdt),
      .man_err (man_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int                cyc;
      logic              vld;
      logic              wen;
      logic [ADR-1:0]    adr;
      logic [BEW-1:0]    ben;
      logic [DAT-1:0]    wdt;
      logic [MPN-1:0]    rdy;
      logic [MPN-1:0]    err;
      logic [DAT-1:0]    rdt;
      int                stall_id;
   } exp_t;

   typedef struct {
      int due;
      int id;
   } rsp_t;

   exp_t eq[$];
   rsp_t rq[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state: who should be served next and who is stuck
   int mptr     = 0;
   int stalled  = -1;
   int prev_w   = -1;
   logic prev_xfer = 1'b0;

   logic              req_on [MPN];
   logic              r_wen  [MPN];
   logic [ADR-1:0]    r_adr  [MPN];
   logic [BEW-1:0]    r_ben  [MPN];
   logic [DAT-1:0]    r_wdt  [MPN];

   int p_req = 0;
   int p_rdy = 0;

   task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
      end
   endtask

   // one bus cycle: drive stimulus, predict the outcome, advance the model
   task automatic step(input logic do_rst);
      exp_t e;
      int   w;
      int   best;
      int   eid;
      logic x;
      @(posedge clk);
      #1;
      cyc++;
      if (prev_xfer) req_on[prev_w] = 1'b0;
      prev_xfer = 1'b0;
      rst = do_rst;
      if (do_rst) begin
         mptr    = 0;
         stalled = -1;
         rq.delete();
      end
      for (int i = 0; i < MPN; i++) begin
         if (!req_on[i] && ($urandom % 100) < p_req) begin
            req_on[i] = 1'b1;
            r_wen[i]  = 1'($urandom);
            r_adr[i]  = $urandom;
            r_ben[i]  = BEW'($urandom);
            r_wdt[i]  = $urandom;
         end
         sub_vld[i] = req_on[i];
         sub_wen[i] = r_wen[i];
         sub_adr[i] = r_adr[i];
         sub_ben[i] = r_ben[i];
         sub_wdt[i] = r_wdt[i];
      end
      man_rdy = do_rst ? 1'b0 : (($urandom % 100) < p_rdy);
      man_rdt = $urandom;
      man_err = 1'($urandom);

      eid = -1;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         eid = rq[0].id;
         void'(rq.pop_front());
      end

      w = -1;
      if (stalled >= 0) begin
         w = stalled;
      end else begin
         best = MPN;
         for (int i = 0; i < MPN; i++) begin
            if (req_on[i] && ((i - mptr + MPN) % MPN) < best) begin
               best = (i - mptr + MPN) % MPN;
               w    = i;
            end
         end
      end

      e.cyc      = cyc;
      e.vld      = (w >= 0);
      e.wen      = (w >= 0) ? r_wen[w] : 1'b0;
      e.adr      = (w >= 0) ? r_adr[w] : '0;
      e.ben      = (w >= 0) ? r_ben[w] : '0;
      e.wdt      = (w >= 0) ? r_wdt[w] : '0;
      e.rdy      = '0;
      if (w >= 0) e.rdy[w] = man_rdy;
      e.err      = '0;
      if (eid >= 0) e.err[eid] = man_err;
      e.rdt      = man_rdt;
      e.stall_id = stalled;
      eq.push_back(e);

      x = (w >= 0) && man_rdy && !do_rst;
      if (!do_rst && w >= 0) begin
         if (x) begin
            mptr      = (w + 1) % MPN;
            stalled   = -1;
            prev_xfer = 1'b1;
            prev_w    = w;
            rq.push_back('{due: cyc + DLY, id: w});
         end else begin
            stalled = w;
         end
      end
   endtask

   // monitor: compare the DUT against the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (eq.size() > 0) begin
            e = eq.pop_front();
            if (e.stall_id >= 0)
               assert (sub_vld[e.stall_id]) else $error("locked manager dropped its request");
            chk("man_vld", e.cyc, 64'(man_vld), 64'(e.vld));
            if (e.vld) begin
               chk("man_wen", e.cyc, 64'(man_wen), 64'(e.wen));
               chk("man_adr", e.cyc, 64'(man_adr), 64'(e.adr));
               chk("man_ben", e.cyc, 64'(man_ben), 64'(e.ben));
               chk("man_wdt", e.cyc, 64'(man_wdt), 64'(e.wdt));
            end
            chk("sub_rdy", e.cyc, 64'(sub_rdy), 64'(e.rdy));
            chk("sub_err", e.cyc, 64'(sub_err), 64'(e.err));
            for (int i = 0; i < MPN; i++)
               chk("sub_rdt", e.cyc, 64'(sub_rdt[i]), 64'(e.rdt));
         end
      end
   end

   initial begin
      rst     = 1'b1;
      sub_vld = '0;
      sub_wen = '0;
      sub_adr = '0;
      sub_ben = '0;
      sub_wdt = '0;
      man_rdy = 1'b0;
      man_rdt = '0;
      man_err = 1'b0;
      for (int i = 0; i < MPN; i++) begin
         req_on[i] = 1'b0;
         r_wen[i]  = 1'b0;
         r_adr[i]  = '0;
         r_ben[i]  = '0;
         r_wdt[i]  = '0;
      end

      // reset state with no requests
      p_req = 0;
      repeat (3) step(1'b1);
      repeat (2) step(1'b0);

      // contention: everybody requesting, subordinate always ready
      p_req = 100;
      p_rdy = 100;
      repeat (12) step(1'b0);

      // stall and lock: subordinate holds off while others keep requesting
      p_rdy = 0;
      repeat (4) step(1'b0);
      p_rdy = 100;
      repeat (6) step(1'b0);

      // reset one cycle after a transfer, with responses still in flight
      repeat (2) step(1'b0);
      step(1'b1);
      repeat (3) step(1'b0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         p_req = 20 + int'($urandom % 81);
         p_rdy = 30 + int'($urandom % 71);
         step(($urandom % 100) < 2);
      end

      p_req = 0;
      p_rdy = 100;
      repeat (6) step(1'b0);
      repeat (3) @(negedge clk);
      chk("queue_drained", cyc, 64'(eq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
